// File: rtl/gate_seq_pkg.sv
// Shared types for the gate vector sequencer: FSM state encoding,
// settle-counter width and the vector-count helper.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Settle interval is at most 255 cycles.
    localparam int SETTLE_W = 8;

    // Number of input vectors a sweep walks for an n-input gate.
    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter that times the settle interval. The value is loaded
// with the settle length; expired is high in the cycle whose closing edge
// brings the count to zero, so a load of S yields exactly S waiting cycles.
module gate_settle_timer
    import gate_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] settle_val,
    output logic                expired
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = settle_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = !load && (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/gate_vector_seq.sv
// Clocked stimulus sequencer and checker for a combinational N_IN-input gate.
// Walks every input vector, waits SETTLE cycles, samples gate_in against the
// TRUTH table and reports err_cnt / pass / done.
// Optional feature: define FIRST_FAIL_CAPTURE_EN to add fail_valid/fail_vec,
// which latch the index of the first mismatching vector of a sweep.
module gate_vector_seq
    import gate_seq_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 4,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b1110
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            gate_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
`endif
);

    localparam int                  NVEC     = vec_count(N_IN);
    localparam logic [N_IN-1:0]     LAST_IDX = N_IN'(NVEC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic            fv_q, fv_d;
    logic [N_IN-1:0] fvec_q, fvec_d;
`endif

    logic timer_load;
    logic timer_expired;
    logic mismatch;

    gate_settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .settle_val (SETTLE_V),
        .expired    (timer_expired)
    );

    assign mismatch = (gate_in != TRUTH[idx_q]);

    // Next-state and datapath: one vector per DRIVE -> SETTLE -> SAMPLE pass.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
        fv_d       = fv_q;
        fvec_d     = fvec_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
                    fv_d    = 1'b0;
                    fvec_d  = '0;
`endif
                end
            end
            ST_DRIVE: begin
                vec_d      = idx_q;
                timer_load = 1'b1;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN+1)'(1);
`ifdef FIRST_FAIL_CAPTURE_EN
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = idx_q;
                    end
`endif
                end
                // Terminal check before increment: idx never wraps in a sweep.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any sweep in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fv_q    <= 1'b0;
            fvec_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
`endif
        end
    end

    assign vec_out = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;
`endif

endmodule

// File: tb/tb_gate_vector_seq.sv
// Bench for gate_vector_seq: two instances (2-input OR, SETTLE=4; 3-input OR,
// SETTLE=1) driven by a behavioural gate model. The reference model tracks
// only the edge count since the accepting start edge and derives every output
// from the sweep timing (SETTLE+2 cycles per vector) and the truth tables.
module tb_gate_vector_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] st;
    logic [1:0] gin;
    logic [1:0] busy, done, pass;
    logic [1:0] vec_a;
    logic [2:0] vec_b;
    logic [2:0] err_a;
    logic [3:0] err_b;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [1:0] fv;
    logic [1:0] fvec_a;
    logic [2:0] fvec_b;
`endif

    gate_vector_seq #(.N_IN(2), .SETTLE(4), .TRUTH(4'b1110)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .gate_in(gin[0]),
        .vec_out(vec_a), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err_a)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .fail_valid(fv[0]), .fail_vec(fvec_a)
`endif
    );

    gate_vector_seq #(.N_IN(3), .SETTLE(1), .TRUTH(8'hFE)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .gate_in(gin[1]),
        .vec_out(vec_b), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err_b)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .fail_valid(fv[1]), .fail_vec(fvec_b)
`endif
    );

    // ---------------- reference model ----------------
    int         per  [2] = '{6, 3};          // SETTLE+2 cycles per vector
    int         nv   [2] = '{4, 8};          // vectors per sweep
    logic [7:0] tr   [2] = '{8'h0E, 8'hFE};  // expected truth tables
    logic       started [2] = '{1'b0, 1'b0};
    int         tcnt [2] = '{0, 0};          // edges since accepting start
    int         prevv[2] = '{0, 0};          // vec_out held at accept time
    logic [7:0] mask [2] = '{8'h0E, 8'hFE};  // gate function for next sweep
    logic [7:0] mlat [2] = '{8'h0E, 8'hFE};  // gate function of current sweep

    int  nchk = 0;
    int  nerr = 0;
    bit  chk_en = 1'b0;
    logic       glitch_en = 1'b0;
    logic [1:0] noise = 2'b00;
    logic [1:0] samp;

    function automatic int e_vec(input int k);
        int t;
        if (!started[k]) return 0;
        if (tcnt[k] == 0) return prevv[k];
        t = (tcnt[k] - 1) / per[k];
        return (t > nv[k] - 1) ? nv[k] - 1 : t;
    endfunction

    function automatic int e_err(input int k);
        int c = 0;
        if (!started[k]) return 0;
        for (int j = 0; j < nv[k]; j++)
            if ((j + 1) * per[k] <= tcnt[k] && mlat[k][j] != tr[k][j]) c++;
        return c;
    endfunction

    function automatic int e_ffv(input int k);
        if (!started[k]) return -1;
        for (int j = 0; j < nv[k]; j++)
            if ((j + 1) * per[k] <= tcnt[k] && mlat[k][j] != tr[k][j]) return j;
        return -1;
    endfunction

    function automatic bit e_busy(input int k);
        return started[k] && tcnt[k] < nv[k] * per[k];
    endfunction

    function automatic bit e_done(input int k);
        return started[k] && tcnt[k] >= nv[k] * per[k];
    endfunction

    // Model advance: reset, start acceptance when not busy, edge counting.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                started[k] <= 1'b0;
                tcnt[k]    <= 0;
                prevv[k]   <= 0;
            end else if (st[k] && !e_busy(k)) begin
                started[k] <= 1'b1;
                tcnt[k]    <= 0;
                prevv[k]   <= e_vec(k);
                mlat[k]    <= mask[k];
            end else if (e_busy(k)) begin
                tcnt[k]    <= tcnt[k] + 1;
            end
        end
    end

    // Sample cycle of each vector: the cycle ending at edge (j+1)*per.
    always_comb begin
        samp = 2'b00;
        for (int k = 0; k < 2; k++)
            samp[k] = e_busy(k) && ((tcnt[k] + 1) % per[k] == 0);
    end

    always @(negedge clk) noise <= 2'($urandom);

    // Gate under test, with glitches outside the sample cycle when enabled.
    assign gin[0] = mlat[0][vec_a] ^ (glitch_en & noise[0] & ~samp[0]);
    assign gin[1] = mlat[1][vec_b] ^ (glitch_en & noise[1] & ~samp[1]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.vec_out", 32'(vec_a), 32'(e_vec(0)));
            chk("a.busy",    32'(busy[0]), 32'(e_busy(0)));
            chk("a.done",    32'(done[0]), 32'(e_done(0)));
            chk("a.pass",    32'(pass[0]), 32'(e_done(0) && e_err(0) == 0));
            chk("a.err_cnt", 32'(err_a), 32'(e_err(0)));
            chk("b.vec_out", 32'(vec_b), 32'(e_vec(1)));
            chk("b.busy",    32'(busy[1]), 32'(e_busy(1)));
            chk("b.done",    32'(done[1]), 32'(e_done(1)));
            chk("b.pass",    32'(pass[1]), 32'(e_done(1) && e_err(1) == 0));
            chk("b.err_cnt", 32'(err_b), 32'(e_err(1)));
`ifdef FIRST_FAIL_CAPTURE_EN
            chk("a.fail_valid", 32'(fv[0]), 32'(e_ffv(0) >= 0));
            chk("a.fail_vec",   32'(fvec_a), 32'(e_ffv(0) >= 0 ? e_ffv(0) : 0));
            chk("b.fail_valid", 32'(fv[1]), 32'(e_ffv(1) >= 0));
            chk("b.fail_vec",   32'(fvec_b), 32'(e_ffv(1) >= 0 ? e_ffv(1) : 0));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [1:0] m);
        @(negedge clk);
        st = m;
        @(negedge clk);
        st = 2'b00;
    endtask

    // Wait for done on instance k; returns edges since the accepting edge.
    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (!done[k] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!done[k]) begin
            nchk++;
            nerr++;
            $display("FAIL timeout.%0d: done not seen after %0d cycles", k, cyc);
        end
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0;
        st    = 2'b00;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.vec_a", 32'(vec_a), 32'd0);
        chk("rst.err_a", 32'(err_a), 32'd0);
        rst_n = 1'b1;

        // Correct OR gates on both instances: 24 cycles busy, pass.
        pulse(2'b11);
        wait_done(0, cyc);
        chk("or.a.done_edge", 32'(cyc), 32'd24);
        chk("or.b.done_same_edge", 32'(done[1]), 32'd1);
        chk("or.a.pass", 32'(pass[0]), 32'd1);
        chk("or.a.err", 32'(err_a), 32'd0);
        chk("or.b.pass", 32'(pass[1]), 32'd1);

        // NOR wired in; a start at cycle 10 must be ignored.
        mask[0] = 8'h01;
        pulse(2'b01);
        cyc = 0;
        while (!done[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
            st[0] = (cyc == 10);
        end
        st[0] = 1'b0;
        chk("nor.a.done_edge", 32'(cyc), 32'd24);
        chk("nor.a.err", 32'(err_a), 32'd4);
        chk("nor.a.pass", 32'(pass[0]), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("nor.a.fail_vec", 32'(fvec_a), 32'd0);
        chk("nor.a.fail_valid", 32'(fv[0]), 32'd1);
`endif

        // Stuck-at-0 output; start from DONE clears the previous result.
        mask[0] = 8'h00;
        pulse(2'b01);
        chk("sa0.a.done_cleared", 32'(done[0]), 32'd0);
        chk("sa0.a.err_cleared", 32'(err_a), 32'd0);
        wait_done(0, cyc);
        chk("sa0.a.err", 32'(err_a), 32'd3);
        chk("sa0.a.pass", 32'(pass[0]), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("sa0.a.fail_vec", 32'(fvec_a), 32'd1);
`endif

        // Reset during vector 2 settle, then a fresh sweep.
        mask[0] = 8'h0E;
        pulse(2'b01);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.a.busy", 32'(busy[0]), 32'd0);
        chk("midrst.a.vec", 32'(vec_a), 32'd0);
        chk("midrst.a.done", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        pulse(2'b01);
        wait_done(0, cyc);
        chk("midrst.a.done_edge", 32'(cyc), 32'd24);
        chk("midrst.a.pass", 32'(pass[0]), 32'd1);

        // Random gate functions, glitches, start pulses and resets.
        glitch_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 97 == 0) begin
                mask[0] = 8'($urandom_range(0, 15));
                mask[1] = 8'($urandom);
            end
            st[0] = ($urandom_range(0, 7) == 0);
            st[1] = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        st    = 2'b00;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
